// File: rtl/uart_tx_engine_pkg.sv
// Shared UART definitions: transmitter state codes, word-length encodings and
// FIFO count width default, also consumed by the debug register interface.
package uart_tx_engine_pkg;

   localparam int UART_FIFO_COUNTER_W_DEF = 5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP    = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP1  = 3'd5,
      S_STOP2  = 3'd6
   } tx_state_e;

   localparam logic [1:0] WL_5 = 2'b00;
   localparam logic [1:0] WL_6 = 2'b01;
   localparam logic [1:0] WL_7 = 2'b10;
   localparam logic [1:0] WL_8 = 2'b11;

   // Index of the final data bit for a word-length code.
   function automatic logic [2:0] last_bit(input logic [1:0] wl);
      case (wl)
         WL_5:    return 3'd4;
         WL_6:    return 3'd5;
         WL_7:    return 3'd6;
         default: return 3'd7;
      endcase
   endfunction

   // Mask of the data bits that actually go on the line.
   function automatic logic [7:0] word_mask(input logic [1:0] wl);
      case (wl)
         WL_5:    return 8'h1F;
         WL_6:    return 8'h3F;
         WL_7:    return 8'h7F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops the TX FIFO head, serializes start/data/parity/
// stop bits at 16 enable ticks per bit, registered line output with live break.
module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int UART_FIFO_COUNTER_W = UART_FIFO_COUNTER_W_DEF
) (
   input  logic                           clk,
   input  logic                           wb_rst_ni,
   input  logic                           enable,
   input  logic [7:0]                     lcr,
   input  logic [7:0]                     tf_data_i,
   input  logic [UART_FIFO_COUNTER_W-1:0] tf_count_i,
   output logic                           tf_pop_o,
   output logic                           stx_pad_o,
   output logic [2:0]                     tstate,
   output logic                           thre_o,
   output logic                           temt_o
);

   tx_state_e  state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] data_q, data_d;
   logic [5:0] lcr_q, lcr_d;
   logic       line_d;
   logic       fifo_empty;
   logic       half_stop;
   logic       bit_end;
   logic       par_bit;

   assign fifo_empty = (tf_count_i == '0);
   assign half_stop  = (state_q == S_STOP2) && (lcr_q[1:0] == WL_5);
   assign bit_end    = enable && (tick_q == (half_stop ? 4'd7 : 4'd15));

   // Stick parity sends ~EPS; otherwise EPS selects even (XOR) vs odd.
   assign par_bit = lcr_q[5] ? ~lcr_q[4]
                             : (^(data_q & word_mask(lcr_q[1:0]))) ^ ~lcr_q[4];

   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q   <= S_IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         data_q    <= '0;
         lcr_q     <= '0;
         stx_pad_o <= 1'b1;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         data_q    <= data_d;
         lcr_q     <= lcr_d;
         stx_pad_o <= lcr[6] ? 1'b0 : line_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      data_d   = data_q;
      lcr_d    = lcr_q;
      line_d   = 1'b1;
      tf_pop_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_POP;
         end
         S_POP: begin
            tf_pop_o = !fifo_empty;
            data_d   = tf_data_i;
            lcr_d    = lcr[5:0];
            tick_d   = '0;
            bit_d    = '0;
            state_d  = fifo_empty ? S_IDLE : S_START;
         end
         S_START: begin
            line_d = 1'b0;
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            line_d = data_q[bit_q];
            if (bit_end) begin
               if (bit_q == last_bit(lcr_q[1:0])) begin
                  bit_d   = '0;
                  state_d = lcr_q[3] ? S_PARITY : S_STOP1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            line_d = par_bit;
            if (bit_end) state_d = S_STOP1;
         end
         S_STOP1: begin
            if (bit_end) state_d = lcr_q[2] ? S_STOP2 : S_IDLE;
         end
         S_STOP2: begin
            if (bit_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (enable && (state_q inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2}))
         tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
   end

   assign tstate = state_q;
   assign thre_o = fifo_empty;
   assign temt_o = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter UART_FIFO_COUNTER_W, default 5, width of the TX FIFO occupancy count.
REQ-002 clk  input  1  block clock; all state changes on rising edge.
REQ-003 wb_rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 enable  input  1  16x-baud tick; one-cycle pulse.
REQ-005 lcr  input  8  line control: [1:0] word length, [2] stop bits, [3] PEN, [4] EPS, [5] stick parity, [6] break.
REQ-006 tf_data_i  input  8  TX FIFO head byte, valid while tf_count_i>0.
REQ-007 tf_count_i  input  UART_FIFO_COUNTER_W  TX FIFO occupancy.
REQ-008 tf_pop_o  output  1  one-cycle FIFO pop strobe.
REQ-009 stx_pad_o  output  1  serial line, idle high.
REQ-010 tstate  output  3  current FSM state code; feeds the debug register word.
REQ-011 thre_o  output  1  holding register empty: tf_count_i==0.
REQ-012 temt_o  output  1  transmitter empty: tstate==IDLE and tf_count_i==0.

Function
REQ-013 States and codes SHALL be: IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP1=5, STOP2=6; code 7 unused, recovers to IDLE next cycle.
REQ-014 IDLE: when tf_count_i>0, SHALL go to POP next cycle, regardless of enable.
REQ-015 POP: tf_pop_o high exactly this one cycle; tf_data_i and lcr[5:0] latched into frame registers; go to START with tick counter cleared.
REQ-016 Every bit period (START, DATA bits, PARITY, STOP1, STOP2 full) SHALL last exactly 16 enable pulses; tick counter 4-bit, wraps 15->0 on transition.
REQ-017 START drives 0; DATA drives latched byte LSB-first, bit count 5/6/7/8 for lcr[1:0]=00/01/10/11; unused upper bits never sent.
REQ-018 After last data bit: PARITY if latched PEN=1, else STOP1.
REQ-019 Parity bit: stick=0, EPS=1 -> even (XOR of sent bits); stick=0, EPS=0 -> odd (inverted XOR); stick=1 -> NOT EPS constant.
REQ-020 STOP1 drives 1; then STOP2 if latched lcr[2]=1, else IDLE.
REQ-021 STOP2 drives 1 for 16 enables, except 8 enables when word length is 5 (1.5 stop bits); then IDLE.
REQ-022 stx_pad_o SHALL be registered (one cycle after state/bit change), never glitching.
REQ-023 lcr[6]=1 SHALL force stx_pad_o to 0 on the next cycle without altering FSM progress; release restores FSM-driven value next cycle.
REQ-024 lcr changes mid-frame SHALL not affect the current frame (only break acts live).
REQ-025 Back-to-back: with tf_count_i>0 at STOP end, IDLE lasts one cycle then POP; no extra idle bit time.
REQ-026 tf_pop_o SHALL never assert when tf_count_i==0.

Reset
REQ-027 On wb_rst_ni low, immediately: tstate=IDLE, stx_pad_o=1, tf_pop_o=0, tick and bit counters=0, frame registers=0.
REQ-028 Reset mid-frame SHALL abort the frame; FIFO entry already popped is lost; first frame after release starts from IDLE.

Structure
REQ-029 State codes, word-length encodings and UART_FIFO_COUNTER_W default SHALL live in the shared UART defines file used by the debug interface.
REQ-030 Single module; parity computed inline; no sub-module.

Verification
REQ-031 8N1, byte 0xA5, enable every 4 clocks: line shows 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; one tf_pop_o pulse; tstate sequence 0,1,2,3,5,0.
REQ-032 7E2 (lcr=0x1E), byte 0x41: 7 data bits 1,0,0,0,0,0,1, parity 0, two stop bits of 16 ticks.
REQ-033 5-bit, 2 stop (lcr=0x04), byte 0x1F: 5 ones after start, STOP1 16 ticks, STOP2 8 ticks; stick parity lcr=0x2C sends 1 then 0 with EPS=1.
REQ-034 tf_count_i=3: three contiguous frames, exactly 3 pops, temt_o rises only after third STOP.
REQ-035 Assert lcr[6] during DATA: stx_pad_o 0 next cycle, tstate continues; deassert -> line resumes frame value.
REQ-036 Drop wb_rst_ni mid-DATA: stx_pad_o=1 and tstate=0 without clock edge; release with tf_count_i=0 keeps line idle high.
